prog_loader: RTL and testbench



---
 rtl/prog_loader_pkg.sv | 33 +++
 rtl/prog_loader_uart_rx.sv | 100 ++++++++++
 rtl/prog_loader.sv | 164 ++++++++++++++++
 tb/tb_prog_loader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and frame constants for the serial program loader.
// Holds the loader/receiver state encodings and the on-the-wire byte order.
package prog_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;

  // Length and data words travel most-significant byte first.
  localparam int MSB_FIRST = 1;

  function automatic logic [15:0] be16(input logic [7:0] first, input logic [7:0] second);
    return (MSB_FIRST != 0) ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// UART byte receiver: 2-flop synchronizer, half-bit start re-check, mid-bit sampling, LSB first.
// rx_valid_o pulses one cycle after the stop-bit sample; no backpressure, a byte is dropped if unused.
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 174
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       rx_ferr_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e   state_q, state_d;
  logic [2:0]  sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        valid_q, valid_d;
  logic [7:0]  data_q, data_d;
  logic        ferr_q, ferr_d;
  logic        line, line_prev;

  // sync_q[1] is the synchronized line; sync_q[2] is its previous value for edge detect.
  assign line      = sync_q[1];
  assign line_prev = sync_q[2];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], rxd_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    data_d  = data_q;
    ferr_d  = ferr_q;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (line_prev && !line) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = line ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          sh_d  = {line, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          valid_d = 1'b1;
          data_d  = sh_q;
          ferr_d  = !line;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_valid_o = valid_q;
  assign rx_data_o  = data_q;
  assign rx_ferr_o  = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// Frame loader: HEADER, LEN(2), N words (hi,lo), XOR checksum -> RAM writes from address 0.
// mem_wren fires the cycle after each low byte; no backpressure, RAM must accept every strobe.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT   = 174,
  parameter int          ADDR_W         = 12,
  parameter int          TIMEOUT_CYCLES = 2_000_000,
  parameter logic [7:0]  HEADER         = FRAME_HEADER
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rxd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              mem_wren,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   MAX_WORDS = 17'(2 ** ADDR_W);

  logic       rx_valid, rx_ferr;
  logic [7:0] rx_data;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i      (clk),
    .rst_i      (reset),
    .rxd_i      (rxd),
    .rx_valid_o (rx_valid),
    .rx_data_o  (rx_data),
    .rx_ferr_o  (rx_ferr)
  );

  ld_state_e         state_q, state_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        chk_q, chk_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic              in_frame;
  logic [ADDR_W:0]   wl_inc;
  logic [15:0]       n_rx;

  assign in_frame = (state_q inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CHECK});
  assign wl_inc   = wl_q + (ADDR_W + 1)'(1);
  assign n_rx     = be16(len_hi_q, rx_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wl_q     <= '0;
      len_hi_q <= '0;
      len_q    <= '0;
      hi_q     <= '0;
      chk_q    <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      tmo_q    <= '0;
      hold_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wl_q     <= wl_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      hi_q     <= hi_d;
      chk_q    <= chk_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      tmo_q    <= tmo_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wl_d     = wl_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    hi_d     = hi_q;
    chk_d    = chk_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    tmo_d    = tmo_q;
    hold_d   = hold_q;
    done_d   = done_q;
    err_d    = err_q;
    if (in_frame) tmo_d = rx_valid ? '0 : tmo_q + TW'(1);
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (rx_valid && !rx_ferr && rx_data == HEADER) begin
          state_d = S_LEN_HI;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          wl_d    = '0;
          chk_d   = '0;
          tmo_d   = '0;
        end
      end
      S_LEN_HI: if (rx_valid) begin
        len_hi_d = rx_data;
        state_d  = S_LEN_LO;
      end
      S_LEN_LO: if (rx_valid) begin
        len_d = n_rx;
        if (n_rx == 16'd0)                 state_d = S_CHECK;
        else if ({1'b0, n_rx} > MAX_WORDS) state_d = S_ERROR;
        else                               state_d = S_DATA_HI;
      end
      S_DATA_HI: if (rx_valid) begin
        hi_d    = rx_data;
        chk_d   = chk_q ^ rx_data;
        state_d = S_DATA_LO;
      end
      S_DATA_LO: if (rx_valid) begin
        chk_d   = chk_q ^ rx_data;
        wdata_d = be16(hi_q, rx_data);
        waddr_d = wl_q[ADDR_W-1:0];
        state_d = S_WRITE;
      end
      S_WRITE: begin
        wl_d    = wl_inc;
        state_d = (16'(wl_inc) == len_q) ? S_CHECK : S_DATA_HI;
      end
      S_CHECK: if (rx_valid) begin
        state_d = (rx_data == chk_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
    // A received byte clears the timeout, so it always wins over a same-cycle expiry.
    if (in_frame && ((rx_valid && rx_ferr) || (!rx_valid && tmo_q == TMO_LAST)))
      state_d = S_ERROR;
    if (state_d == S_ERROR) begin
      err_d  = 1'b1;
      done_d = 1'b0;
      hold_d = 1'b1;
    end else if (state_d == S_DONE) begin
      done_d = 1'b1;
      hold_d = 1'b0;
    end
  end

  assign mem_wren     = (state_q == S_WRITE);
  assign mem_addr     = waddr_q;
  assign mem_data     = wdata_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed frames over a modelled UART line; expected RAM writes are queued by the
// stimulus and consumed by an independent write monitor, status outputs checked after each frame.
module tb_prog_loader;

  localparam int CPB = 16;
  localparam int AW  = 4;
  localparam int TMO = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          rxd;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic          mem_wren;
  logic          cpu_hold;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW+15:0] exp_q[$];
  logic [15:0]    wq[$];
  logic [AW+15:0] e;

  always #5 clk = ~clk;

  prog_loader #(
    .CLKS_PER_BIT   (CPB),
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TMO),
    .HEADER         (8'hA5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rxd          (rxd),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_wren     (mem_wren),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_wren) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL wr_unexpected: got addr %0h data %0h, no write expected", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} === e) n_pass++;
        else $display("FAIL wr_data: got addr %0h data %0h expected addr %0h data %0h",
                      mem_addr, mem_data, e[AW+15:16], e[15:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Sends header, length n, the words in wq and an XOR checksum (or 00 when bad_chk).
  task automatic send_frame(input logic [15:0] n, input bit bad_chk);
    logic [7:0] chk;
    chk = 8'h00;
    send_byte(8'hA5);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    foreach (wq[i]) begin
      exp_q.push_back({AW'(i), wq[i]});
      chk = chk ^ wq[i][15:8] ^ wq[i][7:0];
      send_byte(wq[i][15:8]);
      send_byte(wq[i][7:0]);
    end
    send_byte(bad_chk ? 8'h00 : chk);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic ed, input logic ee,
                              input logic eh, input int ew);
    check({tag, "_done"},  {31'd0, done},       {31'd0, ed});
    check({tag, "_err"},   {31'd0, err},        {31'd0, ee});
    check({tag, "_hold"},  {31'd0, cpu_hold},   {31'd0, eh});
    check({tag, "_words"}, 32'(words_loaded),   32'(ew));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_wren", {31'd0, mem_wren}, 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_data), 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Good frame: 12 34 AB CD, checksum 12^34^AB^CD = 40.
    wq = '{16'h1234, 16'hABCD};
    send_frame(16'd2, 1'b0);
    check_status("good", 1'b1, 1'b0, 1'b0, 2);

    // Same data, wrong checksum: writes still land, load marked bad.
    send_frame(16'd2, 1'b1);
    check_status("badchk", 1'b0, 1'b1, 1'b1, 2);

    send_frame(16'd2, 1'b0);
    check_status("recover", 1'b1, 1'b0, 1'b0, 2);

    wq = {};
    send_frame(16'd0, 1'b0);
    check_status("zero", 1'b1, 1'b0, 1'b0, 0);

    // 17 words exceeds 2^4.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h11);
    repeat (3) @(negedge clk);
    check_status("oversize", 1'b0, 1'b1, 1'b1, 0);

    for (int i = 0; i < 16; i++) wq.push_back({4'(i), 4'h5, ~4'(i), 4'(15 - i)});
    send_frame(16'd16, 1'b0);
    check_status("full", 1'b1, 1'b0, 1'b0, 16);

    // Timeout after the first data byte.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
    repeat (TMO - 100) @(negedge clk);
    check("tmo_early_err", {31'd0, err}, 32'd0);
    repeat (200) @(negedge clk);
    check_status("tmo", 1'b0, 1'b1, 1'b1, 0);

    // Framing error on a data byte.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    check("ferr_pre_err", {31'd0, err}, 32'd0);
    send_byte(8'h12, 1'b0);
    repeat (3) @(negedge clk);
    check_status("ferr", 1'b0, 1'b1, 1'b1, 0);

    // 5-cycle low glitch, then a frame starting while a false start would still be busy.
    repeat (20) @(negedge clk);
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    wq = '{16'h1234, 16'hABCD};
    send_frame(16'd2, 1'b0);
    check_status("glitch", 1'b1, 1'b0, 1'b0, 2);

    // Reset after LEN_LO, then a clean reload.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_status("midrst", 1'b0, 1'b0, 1'b0, 0);
    check("midrst_data", 32'(mem_data), 32'd0);
    check("midrst_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    wq = '{16'h0F0F, 16'hC3A5};
    send_frame(16'd2, 1'b0);
    check_status("reload", 1'b1, 1'b0, 1'b0, 2);

    repeat (10) @(negedge clk);
    check("wr_outstanding", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
